// File: rtl/aqe_portb_cmd_fetch.sv
// aqe_portb_cmd_fetch: streams a block of command words from AQE SRAM port B into a FIFO, then writes a completion word
module aqe_portb_cmd_fetch #(
  parameter int ADDR_W     = 20,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              pll_core_cpuclk,
  input  logic              pad_cpu_rst_b,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        word_len,
  input  logic [ADDR_W-1:0] status_addr,
  output logic [ADDR_W-1:0] dram1_portb_addr,
  output logic [15:0]       dram1_portb_wen,
  output logic [127:0]      dram1_portb_din,
  input  logic [127:0]      dram1_portb_dout,
  output logic              cmd_valid,
  output logic [127:0]      cmd_data,
  input  logic              cmd_ready,
  output logic              busy,
  output logic              done
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WRBACK} state_t;
  state_t              state;
  logic [ADDR_W-1:0]   base_q, stat_q;
  logic [7:0]          len_q;
  logic [8:0]          issued, total;
  logic                iss_q;
  logic [RD_LAT-1:0]   pipe;
  logic [127:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       fifo_count;
  logic [7:0]          outstanding;
  logic                push, pop, launch, issue, last_pop;
  // iss_q marks the cycle an address is on the port; pipe then follows it to the dout cycle
  always_comb begin
    outstanding = 8'(fifo_count) + 8'(iss_q);
    for (int k = 0; k < RD_LAT; k++) outstanding = outstanding + 8'(pipe[k]);
  end
  assign total     = {1'b0, len_q} + 9'd1;
  assign push      = pipe[RD_LAT-1];
  assign cmd_valid = fifo_count != '0;
  assign cmd_data  = cmd_valid ? mem[rd_ptr] : '0;
  assign pop       = cmd_valid & cmd_ready;
  assign busy      = state != IDLE;
  assign launch    = state == IDLE && start && !abort;
  assign issue     = state == FETCH && issued != total && outstanding < 8'(FIFO_DEPTH);
  assign last_pop  = state == DRAIN && pop && fifo_count == CW'(1) && !iss_q && pipe == '0;
  always_ff @(posedge pll_core_cpuclk)
    if (push) mem[wr_ptr] <= dram1_portb_dout;
  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b)
    if (!pad_cpu_rst_b) begin
      state            <= IDLE;
      base_q           <= '0;
      stat_q           <= '0;
      len_q            <= '0;
      issued           <= '0;
      iss_q            <= 1'b0;
      pipe             <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_count       <= '0;
      dram1_portb_addr <= '0;
      dram1_portb_wen  <= '0;
      dram1_portb_din  <= '0;
      done             <= 1'b0;
    end else if (abort) begin
      state           <= IDLE;
      iss_q           <= 1'b0;
      pipe            <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_count      <= '0;
      dram1_portb_wen <= '0;
      dram1_portb_din <= '0;
      done            <= 1'b0;
    end else begin
      // the first read goes out with the accepted start to reach 1+RD_LAT+1 latency
      state <= launch ? FETCH :
               (state == FETCH && issued + 9'(issue) == total) ? DRAIN :
               last_pop ? WRBACK :
               state == WRBACK ? IDLE : state;
      iss_q <= launch | issue;
      pipe  <= (pipe << 1) | RD_LAT'(iss_q);
      if (push) wr_ptr <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
      fifo_count      <= fifo_count + CW'(push) - CW'(pop);
      done            <= last_pop;
      dram1_portb_wen <= last_pop ? 16'hFFFF : 16'h0;
      dram1_portb_din <= last_pop ? {96'h0, 8'hA5, 15'h0, issued} : 128'h0;
      if (launch) begin
        base_q           <= base_addr;
        len_q            <= word_len;
        stat_q           <= status_addr;
        issued           <= 9'd1;
        dram1_portb_addr <= base_addr;
      end
      if (issue) begin
        issued           <= issued + 9'd1;
        dram1_portb_addr <= base_q + ADDR_W'(issued);
      end
      if (last_pop) dram1_portb_addr <= stat_q;
    end
endmodule
